stacker: RTL and testbench

Packs a stream of 8-bit pixels into 128-bit chunks, sixteen pixels per chunk, with the first pixel in the least-significant byte. It sits on the write path between the pixel producer and the 128-bit memory/FIFO interface. It is the inverse of our 128-to-8 unstacker: a chunk produced here and fed back through the unstacker emits the same pixels in the same order. `pixel_tlast` closes a chunk early; the unfilled upper bytes are zero-padded and flagged in `chunk_tkeep`.

---
 rtl/stacker.sv | 68 ++++++
 tb/tb_stacker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stacker.sv
// Packs 8-bit pixels into 128-bit chunks (pixel 0 in byte 0); tlast closes a chunk early with zero padding.
// One cycle from closing byte to chunk_tvalid; input stalls only while a closed chunk waits on chunk_tready.
module stacker (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         pixel_tvalid,
   output logic         pixel_tready,
   input  logic [7:0]   pixel_tdata,
   input  logic         pixel_tlast,
   output logic         chunk_tvalid,
   input  logic         chunk_tready,
   output logic [127:0] chunk_tdata,
   output logic [15:0]  chunk_tkeep,
   output logic         chunk_tlast
);

   logic [127:0] asm_data;
   logic [127:0] next_data;
   logic [15:0]  asm_keep;
   logic [15:0]  next_keep;
   logic [3:0]   asm_count;
   logic         accept_in;
   logic         accept_out;
   logic         closing;

   assign pixel_tready = !chunk_tvalid || chunk_tready;
   assign accept_in    = pixel_tvalid && pixel_tready;
   assign accept_out   = chunk_tvalid && chunk_tready;
   assign closing      = accept_in && ((asm_count == 4'd15) || pixel_tlast);

   // Upper bytes of the assembly are always zero, so the merged word is already padded.
   always_comb begin
      next_data = asm_data;
      next_keep = asm_keep;
      next_data[{asm_count, 3'b000} +: 8] = pixel_tdata;
      next_keep[asm_count] = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         asm_data     <= '0;
         asm_keep     <= '0;
         asm_count    <= '0;
         chunk_tvalid <= 1'b0;
         chunk_tdata  <= '0;
         chunk_tkeep  <= '0;
         chunk_tlast  <= 1'b0;
      end else if (closing) begin
         chunk_tdata  <= next_data;
         chunk_tkeep  <= next_keep;
         chunk_tlast  <= pixel_tlast;
         chunk_tvalid <= 1'b1;
         asm_data     <= '0;
         asm_keep     <= '0;
         asm_count    <= '0;
      end else begin
         if (accept_out) begin
            chunk_tvalid <= 1'b0;
         end
         if (accept_in) begin
            asm_data  <= next_data;
            asm_keep  <= next_keep;
            asm_count <= asm_count + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_stacker.sv
// Bench for stacker: queue-based chunk model checked every cycle, plus directed literal checks.
module tb_stacker;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
   } chunk_t;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b1;
   logic         pixel_tvalid = 1'b0;
   logic         pixel_tready;
   logic [7:0]   pixel_tdata = 8'h00;
   logic         pixel_tlast = 1'b0;
   logic         chunk_tvalid;
   logic         chunk_tready = 1'b1;
   logic [127:0] chunk_tdata;
   logic [15:0]  chunk_tkeep;
   logic         chunk_tlast;

   int checks = 0;
   int failures = 0;
   int stall_cnt = 0;

   chunk_t     exp_q[$];
   chunk_t     got_log[$];
   logic [7:0] part[$];

   stacker dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .pixel_tvalid (pixel_tvalid),
      .pixel_tready (pixel_tready),
      .pixel_tdata  (pixel_tdata),
      .pixel_tlast  (pixel_tlast),
      .chunk_tvalid (chunk_tvalid),
      .chunk_tready (chunk_tready),
      .chunk_tdata  (chunk_tdata),
      .chunk_tkeep  (chunk_tkeep),
      .chunk_tlast  (chunk_tlast)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: closed-but-unconsumed chunks sit in exp_q; partial pixels sit in part.
   always @(negedge clk_in or posedge rst_in) begin : model
      logic   exp_valid;
      logic   exp_ready;
      chunk_t c;
      chunk_t g;
      if (rst_in) begin
         exp_q.delete();
         part.delete();
      end else begin
         exp_valid = (exp_q.size() != 0);
         exp_ready = !exp_valid || chunk_tready;
         chk("chunk_tvalid", 128'(chunk_tvalid), 128'(exp_valid));
         chk("pixel_tready", 128'(pixel_tready), 128'(exp_ready));
         if (exp_valid) begin
            chk("chunk_tdata", chunk_tdata, exp_q[0].d);
            chk("chunk_tkeep", 128'(chunk_tkeep), 128'(exp_q[0].k));
            chk("chunk_tlast", 128'(chunk_tlast), 128'(exp_q[0].l));
            if (chunk_tready) begin
               g.d = chunk_tdata;
               g.k = chunk_tkeep;
               g.l = chunk_tlast;
               got_log.push_back(g);
               void'(exp_q.pop_front());
            end
         end
         if (pixel_tvalid && exp_ready) begin
            part.push_back(pixel_tdata);
            if (part.size() == 16 || pixel_tlast) begin
               c.d = '0;
               c.k = '0;
               for (int i = 0; i < part.size(); i++) begin
                  c.d[i*8 +: 8] = part[i];
                  c.k[i] = 1'b1;
               end
               c.l = pixel_tlast;
               exp_q.push_back(c);
               part.delete();
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      bit done = 1'b0;
      pixel_tvalid = 1'b1;
      pixel_tdata  = d;
      pixel_tlast  = l;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk_in);
         if (pixel_tready) done = 1'b1;
         else stall_cnt++;
         @(posedge clk_in);
         #1;
      end
      pixel_tvalid = 1'b0;
      pixel_tlast  = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=stalled required=accepted");
      end
   endtask

   initial begin : stim
      int   base;
      logic acc;

      #1;
      chk("rst_tvalid", 128'(chunk_tvalid), 128'(0));
      chk("rst_tdata", chunk_tdata, 128'(0));
      chk("rst_tkeep", 128'(chunk_tkeep), 128'(0));
      chk("rst_tlast", 128'(chunk_tlast), 128'(0));
      chk("rst_tready", 128'(pixel_tready), 128'(1));
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Full chunk
      for (int i = 0; i < 16; i++) send(8'(i), i == 15);
      chk("full_vld", 128'(chunk_tvalid), 128'(1));
      chk("full_data", chunk_tdata, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("full_keep", 128'(chunk_tkeep), 128'(16'hFFFF));
      chk("full_last", 128'(chunk_tlast), 128'(1));

      // Early close
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b1);
      chk("early_data", chunk_tdata, 128'h00A3A2A1);
      chk("early_keep", 128'(chunk_tkeep), 128'(16'h0007));
      chk("early_last", 128'(chunk_tlast), 128'(1));

      // Streaming
      repeat (2) @(posedge clk_in);
      #1;
      base = got_log.size();
      stall_cnt = 0;
      for (int i = 0; i < 48; i++) send(8'(i), i == 47);
      repeat (3) @(posedge clk_in);
      #1;
      chk("stream_stalls", 128'(stall_cnt), 128'(0));
      chk("stream_count", 128'(got_log.size() - base), 128'(3));
      if (got_log.size() - base == 3) begin
         chk("stream_last0", 128'(got_log[base].l), 128'(0));
         chk("stream_last1", 128'(got_log[base+1].l), 128'(0));
         chk("stream_last2", 128'(got_log[base+2].l), 128'(1));
         chk("stream_data1", got_log[base+1].d, 128'h1F1E1D1C1B1A19181716151413121110);
      end

      // Backpressure, then simultaneous handoff on release
      chunk_tready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b0);
      fork
         send(8'hEE, 1'b1);
         begin
            repeat (10) @(posedge clk_in);
            #1;
            chk("bp_tready", 128'(pixel_tready), 128'(0));
            chk("bp_tvalid", 128'(chunk_tvalid), 128'(1));
            chk("bp_data", chunk_tdata, 128'h3F3E3D3C3B3A39383736353433323130);
            chunk_tready = 1'b1;
         end
      join
      chk("simul_vld", 128'(chunk_tvalid), 128'(1));
      chk("simul_data", chunk_tdata, 128'h000000EE);
      chk("simul_keep", 128'(chunk_tkeep), 128'(16'h0001));
      chk("simul_last", 128'(chunk_tlast), 128'(1));
      repeat (2) @(posedge clk_in);
      #1;

      // Reset mid-chunk
      for (int i = 0; i < 5; i++) send(8'(8'h70 + i), 1'b0);
      @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("midrst_tvalid", 128'(chunk_tvalid), 128'(0));
      chk("midrst_tkeep", 128'(chunk_tkeep), 128'(0));
      chk("midrst_tready", 128'(pixel_tready), 128'(1));
      #1 rst_in = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(8'h60 + i), i == 15);
      chk("midrst_data", chunk_tdata, 128'h6F6E6D6C6B6A69686766656463626160);
      chk("midrst_keep", 128'(chunk_tkeep), 128'(16'hFFFF));

      // Random traffic under random backpressure
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk_in);
         acc = pixel_tvalid && pixel_tready;
         @(posedge clk_in);
         #1;
         if (!pixel_tvalid || acc) begin
            pixel_tvalid = ($urandom_range(0, 3) != 0);
            pixel_tdata  = 8'($urandom);
            pixel_tlast  = ($urandom_range(0, 7) == 0);
         end
         chunk_tready = ($urandom_range(0, 3) != 0);
      end
      pixel_tvalid = 1'b0;
      chunk_tready = 1'b1;
      @(posedge clk_in);
      #1;
      send(8'h00, 1'b1);
      repeat (4) @(posedge clk_in);
      #1;
      chk("drain_queue", 128'(exp_q.size()), 128'(0));
      chk("drain_part", 128'(part.size()), 128'(0));
      chk("drain_vld", 128'(chunk_tvalid), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
